// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, depth and boot state encoding for the memory responder
package mem_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} boot_state_t;
endpackage

// File: rtl/ram_64x8.sv
// ram_64x8: single write port RAM with registered, enabled read; array itself is never reset
module ram_64x8
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: CPU-side RAM with boot sequencing (zero-fill, byte-stream load, CPU release)
module mem_responder
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic [ADDR_W-1:0] adr_bus,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_rst,
  output logic              boot_done,
  output logic              bus_err
);
  boot_state_t state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n, waddr;
  logic [DATA_W-1:0] wdata;
  logic we, re, xfer, bus_err_n, ptr_end;
  assign xfer = ld_valid & ld_ready;
  assign ptr_end = ptr == ADDR_W'(DEPTH - 1);
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    we = 1'b0;
    re = 1'b0;
    waddr = ptr;
    wdata = '0;
    bus_err_n = bus_err;
    case (state)
      S_CLEAR: begin
        we = 1'b1;
        ptr_n = ptr + 1'b1;
        state_n = ptr_end ? S_LOAD : S_CLEAR;
      end
      S_LOAD: begin
        we = xfer;
        wdata = ld_data;
        ptr_n = xfer ? ptr + 1'b1 : ptr;
        state_n = (xfer && (ld_last || ptr_end)) ? S_RUN : S_LOAD;
      end
      default: begin
        we = wr_mem & ~rd_mem;
        re = rd_mem & ~wr_mem;
        waddr = adr_bus;
        wdata = wr_data;
        bus_err_n = bus_err | (rd_mem & wr_mem);
      end
    endcase
  end
  // Handshake/status outputs are registered from the next state so they flip on the entering edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_CLEAR;
      ptr <= '0;
      ld_ready <= 1'b0;
      cpu_rst <= 1'b1;
      boot_done <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      ld_ready <= state_n == S_LOAD;
      cpu_rst <= state_n != S_RUN;
      boot_done <= state_n == S_RUN;
      bus_err <= bus_err_n;
    end
  ram_64x8 u_ram (
    .clk(clk),
    .rst(rst),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .re(re),
    .raddr(adr_bus),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table vectors, corner sequences and random CPU traffic against a memory model
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_mem, wr_mem, ld_valid, ld_last;
  logic [5:0] adr_bus;
  logic [7:0] wr_data, ld_data, rd_data;
  logic ld_ready, cpu_rst, boot_done, bus_err;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] m [64];
  logic [7:0] m_rd;
  logic m_err, m_run;
  int lptr;
  typedef struct {
    logic rd;
    logic wr;
    logic [5:0] adr;
    logic [7:0] d;
    logic [7:0] exp_rd;
    logic exp_err;
  } vec_t;
  vec_t tbl[15];

  always #5 clk = ~clk;

  mem_responder dut (
    .clk(clk), .rst(rst), .rd_mem(rd_mem), .wr_mem(wr_mem), .adr_bus(adr_bus),
    .wr_data(wr_data), .rd_data(rd_data), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .cpu_rst(cpu_rst), .boot_done(boot_done),
    .bus_err(bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset off-edge, checks async values, then checks the 64-cycle clear
  task automatic do_reset();
    #3;
    rst = 1'b0;
    #1;
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_boot_done", boot_done, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_rd_data", rd_data, 0);
    rd_mem = 0; wr_mem = 0; ld_valid = 0; ld_last = 0;
    repeat (3) cyc();
    rst = 1'b1;
    m_rd = 0; m_err = 0; m_run = 0; lptr = 0;
    for (int i = 1; i <= 64; i++) begin
      cyc();
      chk("clear_ld_ready", ld_ready, (i == 64) ? 1 : 0);
      chk("clear_cpu_rst", cpu_rst, 1);
      chk("clear_boot_done", boot_done, 0);
    end
    for (int a = 0; a < 64; a++) m[a] = 8'h00;
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last, input int gap);
    for (int g = 0; g < gap; g++) begin
      ld_valid = 0;
      ld_last = 1'($urandom);
      ld_data = 8'($urandom);
      cyc();
      chk("stall_ld_ready", ld_ready, 1);
      chk("stall_cpu_rst", cpu_rst, 1);
    end
    ld_valid = 1; ld_data = d; ld_last = last;
    cyc();
    ld_valid = 0; ld_last = 0;
    m[lptr] = d;
    lptr++;
    if (last || lptr == 64) m_run = 1;
    chk("load_ld_ready", ld_ready, !m_run);
    chk("load_cpu_rst", cpu_rst, !m_run);
    chk("load_boot_done", boot_done, m_run);
  endtask

  task automatic cpu(input logic rd, input logic wr, input logic [5:0] adr, input logic [7:0] d);
    rd_mem = rd; wr_mem = wr; adr_bus = adr; wr_data = d;
    cyc();
    rd_mem = 0; wr_mem = 0;
    if (m_run) begin
      if (rd && wr) m_err = 1;
      else if (wr) m[adr] = d;
      else if (rd) m_rd = m[adr];
    end
    chk("model_rd_data", rd_data, m_rd);
    chk("model_bus_err", bus_err, m_err);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 6'd0,  8'h00, 8'hA1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 6'd1,  8'h00, 8'hB2, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 6'd2,  8'h00, 8'hC3, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 6'd3,  8'h00, 8'h00, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 6'd5,  8'h00, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 6'd63, 8'h5A, 8'h00, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 6'd63, 8'h00, 8'h5A, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 6'd1,  8'h11, 8'h5A, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 6'd2,  8'h22, 8'h5A, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 6'd3,  8'h33, 8'h5A, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 6'd4,  8'h44, 8'h5A, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 6'd5,  8'h55, 8'h5A, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 6'd10, 8'hFF, 8'h5A, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 6'd10, 8'h00, 8'h00, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 6'd10, 8'h00, 8'h00, 1'b1};
    rd_mem = 0; wr_mem = 0; adr_bus = 0; wr_data = 0;
    ld_valid = 0; ld_data = 0; ld_last = 0;
    m_rd = 0; m_err = 0; m_run = 0; lptr = 0;
    cyc();
    do_reset();
    load_byte(8'hA1, 0, 2);
    cpu(0, 1, 6'd5, 8'h77);
    cpu(1, 1, 6'd5, 8'h77);
    cpu(1, 0, 6'd0, 8'h00);
    chk("load_ignores_cpu", ld_ready, 1);
    load_byte(8'hB2, 0, 3);
    load_byte(8'hC3, 1, 1);
    for (int i = 0; i < 15; i++) begin
      cpu(tbl[i].rd, tbl[i].wr, tbl[i].adr, tbl[i].d);
      chk($sformatf("tbl%0d_rd_data", i), rd_data, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_bus_err", i), bus_err, tbl[i].exp_err);
    end
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 9);
      cpu(r >= 4 && r != 8, r <= 3 || r == 9, 6'($urandom), 8'($urandom));
    end
    do_reset();
    for (int i = 0; i < 64; i++) load_byte(8'($urandom), 0, $urandom_range(0, 2));
    ld_valid = 1; ld_data = 8'hEE; ld_last = 1;
    cyc();
    ld_valid = 0; ld_last = 0;
    chk("extra_ld_ready", ld_ready, 0);
    chk("extra_boot_done", boot_done, 1);
    for (int a = 0; a < 64; a++) cpu(1, 0, 6'(a), 8'h00);
    do_reset();
    load_byte(8'h11, 0, 0);
    load_byte(8'h22, 0, 1);
    do_reset();
    load_byte(8'h00, 1, 0);
    for (int a = 0; a < 64; a++) cpu(1, 0, 6'(a), 8'h00);
    chk("final_boot_done", boot_done, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
